match_controller: RTL and testbench
===================================

# match_controller

Top-level game sequencer for Pong. It owns match state: idle, serve, rally, point scored, pause and game over. It sequences the paddle and ball objects through a one-cycle `objects_reset` pulse and a `play_enable` level, and keeps both players' scores. It sits between the joystick/button inputs, the ball's miss detection and the paddle/ball movement logic, and updates once per frame via `frame_tick`.

## Interface
- `WIN_SCORE`, default 7: points needed to win; valid range 1..15.
- `SERVE_FRAMES`, default 60: frame ticks spent in SERVE before the rally starts.
- `POINT_FRAMES`, default 90: frame ticks spent in POINT before the next serve or game over.
- `SCORE_W`, default 4: width of the score outputs; must hold WIN_SCORE.

Ports:
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  reset; synchronous, active-high.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `start`  in  1  start button level; a rising edge is detected internally.
- `pause`  in  1  pause button level; a rising edge is detected internally.
- `miss_left`  in  1  pulse from the ball: the ball passed the left paddle.
- `miss_right`  in  1  pulse from the ball: the ball passed the right paddle.
- `objects_reset`  out  1  one-cycle pulse telling the paddles and ball to return to their start positions.
- `play_enable`  out  1  high only in PLAY; while low, the ball and paddles hold position.
- `serve_dir`  out  1  initial ball direction: 0 = toward left, 1 = toward right.
- `score_left`  out  SCORE_W  left player's score.
- `score_right`  out  SCORE_W  right player's score.
- `winner`  out  2  0 = none, 1 = left, 2 = right.
- `game_state`  out  3  current state encoding, for the score/HUD renderer.

## Operation
States and encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSE=4, OVER=5.

Reset values:
- State is IDLE.
- Both scores are 0; `winner` is 0; `serve_dir` is 1.
- `objects_reset` and `play_enable` are 0.
- The frame counter is 0.
- The edge-detect history registers are set to 1, so a button held through reset does not cause a spurious edge.

State behaviour:
- **IDLE:** scores are held at 0. A start edge moves to SERVE.
- **SERVE:** on entry, the counter clears and `objects_reset` pulses. The counter increments on each `frame_tick`. When the count reaches SERVE_FRAMES, the state moves to PLAY. If SERVE_FRAMES is 0, PLAY follows on the next cycle.
- **PLAY:** `play_enable` is 1.
  - `miss_left` alone: `score_right` increments, `serve_dir` becomes 0, go to POINT.
  - `miss_right` alone: `score_left` increments, `serve_dir` becomes 1, go to POINT.
  - Both misses in the same cycle: no score change, `serve_dir` is unchanged, go to SERVE (replay).
  - A pause edge moves to PAUSE. If a pause edge and a miss arrive in the same cycle, the miss wins.
- **PAUSE:** `play_enable` is 0. A pause edge or a start edge returns to PLAY. Positions and scores are untouched. Miss pulses are ignored.
- **POINT:** on entry, the counter clears. After POINT_FRAMES ticks:
  - If either score equals WIN_SCORE, go to OVER and set `winner`.
  - Otherwise go to SERVE.
- **OVER:** scores and `winner` are frozen. A start edge clears both scores and `winner` and moves to SERVE; the SERVE-entry `objects_reset` pulse follows.

Arithmetic and boundary rules:
- Scores increment only in PLAY and saturate at WIN_SCORE.
- Miss pulses outside PLAY are ignored.
- A `frame_tick` that coincides with a state entry is not counted.
- The counter is sized as $clog2(max(SERVE_FRAMES, POINT_FRAMES) + 1) and never wraps.
- `reset` asserted in any state returns every output to its reset value on the next edge.

## Timing
- All outputs are registered.
- A qualifying input event in cycle N produces the new state, scores and outputs at edge N+1.
- `objects_reset` is high for exactly the first cycle that `game_state` reads SERVE.
- `play_enable` rises in the same cycle that `game_state` becomes PLAY.
- `play_enable` falls in the same cycle that PLAY is left.
- Button edge detection adds no latency: an edge sampled at cycle N acts at N+1.
- Serve latency: PLAY is entered one cycle after the SERVE_FRAMES-th counted tick.

## Structure
- Shared package `pong_pkg` holds:
  - the state enum and its encodings;
  - the winner codes (NONE, LEFT, RIGHT);
  - the serve direction constants (DIR_LEFT, DIR_RIGHT).
- The HUD renderer and the ball import the same package.
- One sub-module, `frame_timer`: counts `frame_tick` pulses after a clear and asserts `done` when the count reaches a target. It is used for both SERVE and POINT.
- Start and pause edge detection stays inline.

## Test plan
- **Reset and start:** reset, then a start edge -> SERVE next cycle with a single `objects_reset` pulse; after 60 ticks -> PLAY and `play_enable` = 1.
- **Left miss:** `miss_left` pulse in PLAY -> `score_right` = 1, `serve_dir` = 0, POINT; after 90 ticks -> SERVE.
- **Win:** with WIN_SCORE = 2, two `miss_right` rallies -> OVER, `winner` = 1, `score_left` = 2; a later `miss_right` is ignored. A start edge -> scores 0, `winner` 0, SERVE.
- **Simultaneous misses:** `miss_left` and `miss_right` in the same cycle -> scores unchanged, SERVE, `objects_reset` pulses.
- **Pause:** pause edge in PLAY -> PAUSE, `play_enable` = 0; a `miss_left` is ignored; a second pause edge -> PLAY.
- **Reset mid-operation:** reset in POINT mid-count, and `start` held high through reset -> IDLE, all outputs at reset values, no spurious SERVE.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong definitions: match state encodings, winner codes and serve directions.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_PAUSE = 3'd4,
        ST_OVER  = 3'd5
    } match_state_t;

    localparam logic [1:0] WIN_NONE  = 2'd0;
    localparam logic [1:0] WIN_LEFT  = 2'd1;
    localparam logic [1:0] WIN_RIGHT = 2'd2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/match_controller_frame_timer.sv
// Counts frame ticks after a clear; done holds once the count reaches target.
module frame_timer #(
    parameter int unsigned CNT_W = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] target,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Stops at target so the counter never wraps.
    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (tick && (count != target))
            count <= count + 1'b1;
    end

    assign done = (count == target);

endmodule

// File: rtl/match_controller.sv
// Pong match sequencer: serve/rally/point/pause/game-over flow and score keeping.
module match_controller
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 90,
    parameter int unsigned SCORE_W      = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               pause,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               objects_reset,
    output logic               play_enable,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic [1:0]         winner,
    output logic [2:0]         game_state
);

    localparam int unsigned MAX_FRAMES = max_u(SERVE_FRAMES, POINT_FRAMES);
    localparam int unsigned CNT_W      = (MAX_FRAMES > 0) ? $clog2(MAX_FRAMES + 1) : 1;

    localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_T = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0]   POINT_T = CNT_W'(POINT_FRAMES);

    match_state_t       state, next_state;
    logic [SCORE_W-1:0] next_left, next_right;
    logic [1:0]         next_winner;
    logic               next_dir;
    logic               start_q, pause_q;
    logic               start_edge, pause_edge;
    logic               timer_clear, timer_tick, timer_done;
    logic [CNT_W-1:0]   timer_target;

    assign start_edge = start & ~start_q;
    assign pause_edge = pause & ~pause_q;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= WIN_S) ? s : s + 1'b1;
    endfunction

    always_comb begin
        next_state  = state;
        next_left   = score_left;
        next_right  = score_right;
        next_winner = winner;
        next_dir    = serve_dir;
        case (state)
            ST_IDLE:  if (start_edge) next_state = ST_SERVE;
            ST_SERVE: if (timer_done) next_state = ST_PLAY;
            ST_PLAY: begin
                // Misses take priority over a same-cycle pause edge.
                if (miss_left && miss_right) begin
                    next_state = ST_SERVE;
                end else if (miss_left) begin
                    next_right = sat_inc(score_right);
                    next_dir   = DIR_LEFT;
                    next_state = ST_POINT;
                end else if (miss_right) begin
                    next_left  = sat_inc(score_left);
                    next_dir   = DIR_RIGHT;
                    next_state = ST_POINT;
                end else if (pause_edge) begin
                    next_state = ST_PAUSE;
                end
            end
            ST_PAUSE: if (pause_edge || start_edge) next_state = ST_PLAY;
            ST_POINT: begin
                if (timer_done) begin
                    if (score_left == WIN_S) begin
                        next_state  = ST_OVER;
                        next_winner = WIN_LEFT;
                    end else if (score_right == WIN_S) begin
                        next_state  = ST_OVER;
                        next_winner = WIN_RIGHT;
                    end else begin
                        next_state = ST_SERVE;
                    end
                end
            end
            ST_OVER: begin
                if (start_edge) begin
                    next_left   = '0;
                    next_right  = '0;
                    next_winner = WIN_NONE;
                    next_state  = ST_SERVE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign timer_clear  = (next_state != state);
    assign timer_tick   = frame_tick && ((state == ST_SERVE) || (state == ST_POINT));
    assign timer_target = (state == ST_SERVE) ? SERVE_T : POINT_T;

    frame_timer #(.CNT_W(CNT_W)) u_frame_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .tick   (timer_tick),
        .target (timer_target),
        .done   (timer_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            score_left    <= '0;
            score_right   <= '0;
            winner        <= WIN_NONE;
            serve_dir     <= DIR_RIGHT;
            objects_reset <= 1'b0;
            play_enable   <= 1'b0;
            start_q       <= 1'b1;
            pause_q       <= 1'b1;
        end else begin
            state         <= next_state;
            score_left    <= next_left;
            score_right   <= next_right;
            winner        <= next_winner;
            serve_dir     <= next_dir;
            objects_reset <= (next_state == ST_SERVE) && (state != ST_SERVE);
            play_enable   <= (next_state == ST_PLAY);
            start_q       <= start;
            pause_q       <= pause;
        end
    end

    assign game_state = state;

endmodule

// File: tb/tb_match_controller.sv
// Randomized bench for match_controller against a cycle-level behavioural model.
module tb_match_controller;

    localparam int unsigned WIN = 2;
    localparam int unsigned SF  = 60;
    localparam int unsigned PF  = 90;
    localparam int unsigned SW  = 4;

    logic          clock = 1'b0;
    logic          reset, frame_tick, start, pause, miss_left, miss_right;
    logic          objects_reset, play_enable, serve_dir;
    logic [SW-1:0] score_left, score_right;
    logic [1:0]    winner;
    logic [2:0]    game_state;

    int checks = 0;
    int errors = 0;

    // Model state: phase 0..5 = idle, serve, play, point, pause, over.
    int m_phase, m_ticks, m_sl, m_sr, m_win;
    bit m_dir, m_ores, m_pe, m_start_prev, m_pause_prev;

    match_controller #(
        .WIN_SCORE    (WIN),
        .SERVE_FRAMES (SF),
        .POINT_FRAMES (PF),
        .SCORE_W      (SW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .start         (start),
        .pause         (pause),
        .miss_left     (miss_left),
        .miss_right    (miss_right),
        .objects_reset (objects_reset),
        .play_enable   (play_enable),
        .serve_dir     (serve_dir),
        .score_left    (score_left),
        .score_right   (score_right),
        .winner        (winner),
        .game_state    (game_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_ticks = 0; m_sl = 0; m_sr = 0; m_win = 0;
        m_dir = 1'b1; m_ores = 1'b0; m_pe = 1'b0;
        m_start_prev = 1'b1; m_pause_prev = 1'b1;
    endtask

    // Applies the inputs present just before a rising edge.
    task automatic model_step();
        int nxt;
        bit se, pe;
        if (reset) begin
            model_reset();
            return;
        end
        se  = start && !m_start_prev;
        pe  = pause && !m_pause_prev;
        nxt = m_phase;
        case (m_phase)
            0: if (se) nxt = 1;
            1: if (m_ticks >= SF) nxt = 2;
            2: begin
                if (miss_left && miss_right) nxt = 1;
                else if (miss_left) begin
                    m_sr = (m_sr + 1 > WIN) ? WIN : m_sr + 1; m_dir = 1'b0; nxt = 3;
                end else if (miss_right) begin
                    m_sl = (m_sl + 1 > WIN) ? WIN : m_sl + 1; m_dir = 1'b1; nxt = 3;
                end else if (pe) nxt = 4;
            end
            3: if (m_ticks >= PF) begin
                if (m_sl == WIN)      begin nxt = 5; m_win = 1; end
                else if (m_sr == WIN) begin nxt = 5; m_win = 2; end
                else nxt = 1;
            end
            4: if (pe || se) nxt = 2;
            5: if (se) begin m_sl = 0; m_sr = 0; m_win = 0; nxt = 1; end
            default: nxt = 0;
        endcase
        if (nxt != m_phase) m_ticks = 0;
        else if (frame_tick && (m_phase == 1 || m_phase == 3)) m_ticks++;
        m_ores = (nxt == 1) && (m_phase != 1);
        m_pe   = (nxt == 2);
        m_phase = nxt;
        m_start_prev = start;
        m_pause_prev = pause;
    endtask

    task automatic check_all();
        check("game_state",    32'(game_state),    32'(m_phase));
        check("play_enable",   32'(play_enable),   32'(m_pe));
        check("objects_reset", 32'(objects_reset), 32'(m_ores));
        check("serve_dir",     32'(serve_dir),     32'(m_dir));
        check("score_left",    32'(score_left),    32'(m_sl));
        check("score_right",   32'(score_right),   32'(m_sr));
        check("winner",        32'(winner),        32'(m_win));
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; start = 1'b1; pause = 1'b1;
        miss_left = 1'b0; miss_right = 1'b0;
        model_reset();
        repeat (3) cycle();
        // Buttons held through reset must not produce an edge afterwards.
        @(negedge clock) reset = 1'b0;
        repeat (8) cycle();
        check("idle_after_held_start", 32'(game_state), 32'd0);

        for (int n = 0; n < 40000; n++) begin
            @(negedge clock);
            reset      = ($urandom_range(0, 3999) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 63) == 0) start = ~start;
            if ($urandom_range(0, 79) == 0) pause = ~pause;
            miss_left  = ($urandom_range(0, 149) == 0);
            miss_right = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 599) == 0) begin
                miss_left  = 1'b1;
                miss_right = 1'b1;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
